// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch PC sequencer with redirect and drain handling
// Issues one word read per accepted slot and presents the fetched instruction to decode.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc4_q;
  logic        misalign_q;

  logic        accept;
  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;

  assign accept    = !if_valid_q || !stall;
  assign pc_inc    = pc_q + 32'd4;
  assign redir_tgt = {redir_pc[31:2], 2'b00};

  // DRAIN keeps the abandoned address on the bus until memory acknowledges it.
  assign im_req  = ((state_q == FETCH) && accept) || (state_q == DRAIN);
  assign im_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc4       = if_pc4_q;
  assign misalign_exc = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'd0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= 32'd0;
      if_pc_q      <= 32'd0;
      if_pc4_q     <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= redir_valid && (redir_pc[1:0] != 2'b00);
      unique case (state_q)
        BOOT: begin
          state_q <= FETCH;
          if (redir_valid) pc_q <= redir_tgt;
        end
        FETCH: begin
          if (redir_valid) begin
            pc_q       <= redir_tgt;
            if_valid_q <= 1'b0;
            // A same-cycle ack retires the old request, so only a still-open one needs draining.
            if (accept && !im_ack) begin
              state_q      <= DRAIN;
              drain_addr_q <= pc_q;
            end
          end else if (accept && im_ack) begin
            if_instr_q <= im_rdata;
            if_pc_q    <= pc_q;
            if_pc4_q   <= pc_inc;
            if_valid_q <= 1'b1;
            pc_q       <= pc_inc;
          end else if (if_valid_q && !stall) begin
            if_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (redir_valid) pc_q <= redir_tgt;
          if (im_ack) state_q <= FETCH;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed vector table plus randomized run against a fetch-stream model
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, im_ack;
  logic [31:0] redir_pc, im_rdata;
  logic        im_req, if_valid, misalign_exc;
  logic [31:0] im_addr, if_instr, if_pc, if_pc4;

  int total = 0;
  int bad   = 0;

  pc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(input logic stl, rv, input logic [31:0] rpc, input logic ack,
                              input logic [31:0] rd, input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_instr, e_pc, e_pc4,
                              input logic e_mis);
    vec_t v;
    v.rst = 1'b0; v.stl = stl; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, stl, rv, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rd);
    reset = rst; stall = stl; redir_valid = rv; redir_pc = rpc; im_ack = ack; im_rdata = rd;
  endtask

  // Reference model: what the fetch stream should look like, tracked as a few facts.
  logic        m_booting, m_draining;
  logic [31:0] m_pc, m_drain_addr;
  logic        m_val, m_mis;
  logic [31:0] m_instr, m_ifpc, m_ifpc4;

  function automatic logic m_req(input logic stl);
    if (m_booting) return 1'b0;
    if (m_draining) return 1'b1;
    return !m_val || !stl;
  endfunction

  task automatic m_step(input logic rst, stl, rv, input logic [31:0] rpc, input logic ack,
                        input logic [31:0] rd);
    logic        open;
    logic [31:0] tgt;
    open = m_req(stl);
    tgt  = rpc & 32'hFFFF_FFFC;
    if (rst) begin
      m_booting = 1'b1; m_draining = 1'b0; m_pc = 32'h0000_3000; m_drain_addr = 32'd0;
      m_val = 1'b0; m_instr = 32'd0; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_mis = 1'b0;
    end else begin
      m_mis = rv && (rpc % 4 != 0);
      if (m_booting) begin
        m_booting = 1'b0;
        if (rv) m_pc = tgt;
      end else if (m_draining) begin
        if (rv) m_pc = tgt;
        if (ack) m_draining = 1'b0;
      end else if (rv) begin
        if (open && !ack) begin
          m_draining = 1'b1; m_drain_addr = m_pc;
        end
        m_pc = tgt; m_val = 1'b0;
      end else if (open && ack) begin
        m_instr = rd; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_val = 1'b1; m_pc = m_pc + 32'd4;
      end else if (!stl) begin
        m_val = 1'b0;
      end
    end
  endtask

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] A1 = 32'hC0DE_0001, A2 = 32'hC0DE_0002, A3 = 32'hC0DE_0003;
  localparam logic [31:0] A4 = 32'hC0DE_0004, A5 = 32'hC0DE_0005, A6 = 32'hC0DE_0006;

  vec_t tbl[21];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);

    tbl[0]  = mk(0, 0, 32'd0,        0, 32'd0, 0, 32'h3000,     0, 32'd0, 32'd0,        32'd0,    0);
    tbl[1]  = mk(0, 0, 32'd0,        1, A1,    1, 32'h3000,     0, 32'd0, 32'd0,        32'd0,    0);
    tbl[2]  = mk(0, 0, 32'd0,        1, A2,    1, 32'h3004,     1, A1,    32'h3000,     32'h3004, 0);
    tbl[3]  = mk(1, 0, 32'd0,        0, 32'd0, 0, 32'h3008,     1, A2,    32'h3004,     32'h3008, 0);
    tbl[4]  = mk(1, 0, 32'd0,        0, 32'd0, 0, 32'h3008,     1, A2,    32'h3004,     32'h3008, 0);
    tbl[5]  = mk(1, 0, 32'd0,        0, 32'd0, 0, 32'h3008,     1, A2,    32'h3004,     32'h3008, 0);
    tbl[6]  = mk(0, 0, 32'd0,        1, A3,    1, 32'h3008,     1, A2,    32'h3004,     32'h3008, 0);
    tbl[7]  = mk(0, 0, 32'd0,        0, 32'd0, 1, 32'h300C,     1, A3,    32'h3008,     32'h300C, 0);
    tbl[8]  = mk(0, 0, 32'd0,        1, A4,    1, 32'h300C,     0, A3,    32'h3008,     32'h300C, 0);
    tbl[9]  = mk(0, 0, 32'd0,        0, 32'd0, 1, 32'h3010,     1, A4,    32'h300C,     32'h3010, 0);
    tbl[10] = mk(0, 1, 32'h3100,     0, 32'd0, 1, 32'h3010,     0, A4,    32'h300C,     32'h3010, 0);
    tbl[11] = mk(0, 0, 32'd0,        0, 32'd0, 1, 32'h3010,     0, A4,    32'h300C,     32'h3010, 0);
    tbl[12] = mk(0, 0, 32'd0,        1, BAD,   1, 32'h3010,     0, A4,    32'h300C,     32'h3010, 0);
    tbl[13] = mk(0, 0, 32'd0,        0, 32'd0, 1, 32'h3100,     0, A4,    32'h300C,     32'h3010, 0);
    tbl[14] = mk(0, 1, 32'h3102,     0, 32'd0, 1, 32'h3100,     0, A4,    32'h300C,     32'h3010, 0);
    tbl[15] = mk(0, 0, 32'd0,        1, BAD,   1, 32'h3100,     0, A4,    32'h300C,     32'h3010, 1);
    tbl[16] = mk(0, 0, 32'd0,        1, A5,    1, 32'h3100,     0, A4,    32'h300C,     32'h3010, 0);
    tbl[17] = mk(0, 1, 32'hFFFFFFFC, 0, 32'd0, 1, 32'h3104,     1, A5,    32'h3100,     32'h3104, 0);
    tbl[18] = mk(0, 0, 32'd0,        1, BAD,   1, 32'h3104,     0, A5,    32'h3100,     32'h3104, 0);
    tbl[19] = mk(0, 0, 32'd0,        1, A6,    1, 32'hFFFFFFFC, 0, A5,    32'h3100,     32'h3104, 0);
    tbl[20] = mk(0, 0, 32'd0,        0, 32'd0, 1, 32'h0000_0000, 1, A6,   32'hFFFFFFFC, 32'd0,    0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].stl, tbl[i].rv, tbl[i].rpc, tbl[i].ack, tbl[i].rd);
      #1;
      chk($sformatf("v%0d im_req", i),       {31'd0, im_req},       {31'd0, tbl[i].e_req});
      chk($sformatf("v%0d im_addr", i),      im_addr,               tbl[i].e_addr);
      chk($sformatf("v%0d if_valid", i),     {31'd0, if_valid},     {31'd0, tbl[i].e_val});
      chk($sformatf("v%0d if_instr", i),     if_instr,              tbl[i].e_instr);
      chk($sformatf("v%0d if_pc", i),        if_pc,                 tbl[i].e_pc);
      chk($sformatf("v%0d if_pc4", i),       if_pc4,                tbl[i].e_pc4);
      chk($sformatf("v%0d misalign_exc", i), {31'd0, misalign_exc}, {31'd0, tbl[i].e_mis});
    end

    // Reset lands on an open request; the late ack arrives while booting.
    @(negedge clk); drive(0, 0, 0, 32'd0, 0, 32'd0);
    @(negedge clk); drive(1, 0, 0, 32'd0, 0, 32'd0);
    @(negedge clk); drive(0, 0, 0, 32'd0, 1, BAD); #1;
    chk("boot im_req", {31'd0, im_req}, 32'd0);
    chk("boot if_valid", {31'd0, if_valid}, 32'd0);
    chk("boot if_pc", if_pc, 32'd0);
    @(negedge clk); drive(0, 0, 0, 32'd0, 0, 32'd0); #1;
    chk("post-reset im_req", {31'd0, im_req}, 32'd1);
    chk("post-reset im_addr", im_addr, 32'h3000);
    chk("post-reset if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk); #1;
    chk("boot ack ignored", {31'd0, if_valid}, 32'd0);

    // Randomized run against the model.
    @(negedge clk); drive(1, 0, 0, 32'd0, 0, 32'd0);
    m_step(1, 0, 0, 32'd0, 0, 32'd0);
    @(posedge clk);
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_stl, r_rv, r_ack;
      logic [31:0] r_rpc, r_rd;
      @(negedge clk);
      r_rst = ($urandom % 250) == 0;
      r_stl = ($urandom % 3) == 0;
      r_rv  = ($urandom % 12) == 0;
      r_rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      r_rd  = $urandom;
      if (m_req(r_stl))  r_ack = ($urandom % 3) != 0;
      else if (m_booting) r_ack = $urandom % 2;
      else                r_ack = 1'b0;
      drive(r_rst, r_stl, r_rv, r_rpc, r_ack, r_rd);
      #1;
      chk("rnd im_req", {31'd0, im_req}, {31'd0, m_req(r_stl)});
      if (m_req(r_stl)) chk("rnd im_addr", im_addr, m_draining ? m_drain_addr : m_pc);
      chk("rnd if_valid", {31'd0, if_valid}, {31'd0, m_val});
      chk("rnd if_instr", if_instr, m_instr);
      chk("rnd if_pc", if_pc, m_ifpc);
      chk("rnd if_pc4", if_pc4, m_ifpc4);
      chk("rnd misalign_exc", {31'd0, misalign_exc}, {31'd0, m_mis});
      @(posedge clk);
      m_step(r_rst, r_stl, r_rv, r_rpc, r_ack, r_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
